// File: rtl/dsp48a1_pkg.sv
// Shared DSP48A1 slice definitions: OPMODE field positions, operand-select
// encodings and datapath widths.
package dsp48a1_pkg;

    localparam int unsigned P_W = 48;
    localparam int unsigned M_W = 36;

    localparam int unsigned X_SEL_LSB = 0;
    localparam int unsigned X_SEL_MSB = 1;
    localparam int unsigned Z_SEL_LSB = 2;
    localparam int unsigned Z_SEL_MSB = 3;
    localparam int unsigned CIN_BIT   = 5;
    localparam int unsigned SUB_BIT   = 7;

    typedef enum logic [1:0] {
        X_ZERO = 2'd0,
        X_M    = 2'd1,
        X_P    = 2'd2,
        X_DAB  = 2'd3
    } x_sel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PCIN = 2'd1,
        Z_P    = 2'd2,
        Z_C    = 2'd3
    } z_sel_e;

endpackage

// File: rtl/dsp_post_adder_acc_if.sv
// Operand/result bundle of the DSP48A1 post-adder stage.
interface dsp_post_adder_acc_if;
    import dsp48a1_pkg::*;

    logic           CEOPMODE;
    logic           CECARRYIN;
    logic           CEP;
    logic [7:0]     OPMODE;
    logic           CARRYIN;
    logic [M_W-1:0] M;
    logic [P_W-1:0] C;
    logic [P_W-1:0] DAB;
    logic [P_W-1:0] PCIN;
    logic [P_W-1:0] P;
    logic [P_W-1:0] PCOUT;
    logic           CARRYOUT;
    logic           CARRYOUTF;

    modport master (
        output CEOPMODE, CECARRYIN, CEP, OPMODE, CARRYIN, M, C, DAB, PCIN,
        input  P, PCOUT, CARRYOUT, CARRYOUTF
    );

    modport slave (
        input  CEOPMODE, CECARRYIN, CEP, OPMODE, CARRYIN, M, C, DAB, PCIN,
        output P, PCOUT, CARRYOUT, CARRYOUTF
    );

endinterface

// File: rtl/pipeline_stage.sv
// Optional register stage with clock enable; SEL=0 makes it a wire.
// RESET_TYPE selects synchronous ("SYNC") or asynchronous ("ASYNC") clear.
module pipeline_stage #(
    parameter int unsigned WIDTH      = 1,
    parameter bit          SEL        = 1'b1,
    parameter string       RESET_TYPE = "SYNC"
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (!SEL) begin : g_bypass
            assign q = d;
        end else if (RESET_TYPE == "ASYNC") begin : g_async
            always_ff @(posedge CLK or posedge reset) begin
                if (reset)   q <= '0;
                else if (ce) q <= d;
            end
        end else begin : g_sync
            always_ff @(posedge CLK) begin
                if (reset)   q <= '0;
                else if (ce) q <= d;
            end
        end
    endgenerate

endmodule

// File: rtl/dsp_post_adder_acc.sv
// DSP48A1 post-adder/accumulator: OPMODE-selected X/Z operands, add or
// subtract with carry-in, P register with feedback for accumulation.
module dsp_post_adder_acc
    import dsp48a1_pkg::*;
#(
    parameter int unsigned OPMODEREG  = 1,
    parameter int unsigned CARRYINREG = 1,
    parameter int unsigned PREG       = 1,
    parameter string       CARRYINSEL = "OPMODE5"
) (
    input  logic                 CLK,
    input  logic                 reset,
    dsp_post_adder_acc_if.slave  bus
);

    logic [7:0]     opm;
    logic           cin_src;
    logic           cin;
    logic [P_W:0]   p_reg;
    logic [P_W-1:0] p_fb;
    logic [P_W-1:0] x_val;
    logic [P_W-1:0] z_val;
    logic [P_W:0]   result;
    x_sel_e         x_sel;
    z_sel_e         z_sel;

    pipeline_stage #(
        .WIDTH      (8),
        .SEL        (OPMODEREG != 0),
        .RESET_TYPE ("SYNC")
    ) u_opmode_reg (
        .CLK   (CLK),
        .reset (reset),
        .ce    (bus.CEOPMODE),
        .d     (bus.OPMODE),
        .q     (opm)
    );

    // Carry-in source is taken ahead of the OPMODE register so both reach P
    // on the same edge.
    assign cin_src = (CARRYINSEL == "CARRYIN") ? bus.CARRYIN : bus.OPMODE[CIN_BIT];

    pipeline_stage #(
        .WIDTH      (1),
        .SEL        (CARRYINREG != 0),
        .RESET_TYPE ("SYNC")
    ) u_carryin_reg (
        .CLK   (CLK),
        .reset (reset),
        .ce    (bus.CECARRYIN),
        .d     (cin_src),
        .q     (cin)
    );

    // Without PREG the feedback path would be a combinational loop; tie it off.
    assign p_fb = (PREG != 0) ? p_reg[P_W-1:0] : '0;

    assign x_sel = x_sel_e'(opm[X_SEL_MSB:X_SEL_LSB]);
    assign z_sel = z_sel_e'(opm[Z_SEL_MSB:Z_SEL_LSB]);

    always_comb begin
        x_val = '0;
        unique case (x_sel)
            X_ZERO: x_val = '0;
            X_M:    x_val = {{(P_W-M_W){1'b0}}, bus.M};
            X_P:    x_val = p_fb;
            X_DAB:  x_val = bus.DAB;
        endcase
    end

    always_comb begin
        z_val = '0;
        unique case (z_sel)
            Z_ZERO: z_val = '0;
            Z_PCIN: z_val = bus.PCIN;
            Z_P:    z_val = p_fb;
            Z_C:    z_val = bus.C;
        endcase
    end

    always_comb begin
        result = '0;
        if (opm[SUB_BIT])
            result = {1'b0, z_val} - ({1'b0, x_val} + {{P_W{1'b0}}, cin});
        else
            result = {1'b0, z_val} + {1'b0, x_val} + {{P_W{1'b0}}, cin};
    end

    pipeline_stage #(
        .WIDTH      (P_W + 1),
        .SEL        (PREG != 0),
        .RESET_TYPE ("SYNC")
    ) u_p_reg (
        .CLK   (CLK),
        .reset (reset),
        .ce    (bus.CEP),
        .d     (result),
        .q     (p_reg)
    );

    assign bus.P         = p_reg[P_W-1:0];
    assign bus.PCOUT     = p_reg[P_W-1:0];
    assign bus.CARRYOUT  = p_reg[P_W];
    assign bus.CARRYOUTF = p_reg[P_W];

    logic unused_opm_bits;
    assign unused_opm_bits = &{1'b0, opm[6], opm[4], bus.CARRYIN, bus.OPMODE[CIN_BIT]};

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Bench for dsp_post_adder_acc: two instances (carry-in from OPMODE[5] and
// from CARRYIN) driven in lockstep and compared with an arithmetic model.
module tb_dsp_post_adder_acc;

    localparam longint MASK48 = longint'((64'd1 << 48) - 1);
    localparam longint MASK49 = longint'((64'd1 << 49) - 1);

    logic        CLK;
    logic        reset;
    logic        ce_opm, ce_cin, ce_p;
    logic [7:0]  opmode;
    logic        carryin;
    logic [35:0] m;
    logic [47:0] c, dab, pcin;

    int n_checks = 0;
    int n_errors = 0;

    dsp_post_adder_acc_if bus0 ();
    dsp_post_adder_acc_if bus1 ();

    assign bus0.CEOPMODE = ce_opm;  assign bus1.CEOPMODE = ce_opm;
    assign bus0.CECARRYIN = ce_cin; assign bus1.CECARRYIN = ce_cin;
    assign bus0.CEP = ce_p;         assign bus1.CEP = ce_p;
    assign bus0.OPMODE = opmode;    assign bus1.OPMODE = opmode;
    assign bus0.CARRYIN = carryin;  assign bus1.CARRYIN = carryin;
    assign bus0.M = m;              assign bus1.M = m;
    assign bus0.C = c;              assign bus1.C = c;
    assign bus0.DAB = dab;          assign bus1.DAB = dab;
    assign bus0.PCIN = pcin;        assign bus1.PCIN = pcin;

    dsp_post_adder_acc #(
        .OPMODEREG(1), .CARRYINREG(1), .PREG(1), .CARRYINSEL("OPMODE5")
    ) dut0 (.CLK(CLK), .reset(reset), .bus(bus0));

    dsp_post_adder_acc #(
        .OPMODEREG(1), .CARRYINREG(1), .PREG(1), .CARRYINSEL("CARRYIN")
    ) dut1 (.CLK(CLK), .reset(reset), .bus(bus1));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model state: what each instance has captured so far.
    logic [7:0] m_opm;
    bit         m_cin [2];
    longint     m_p   [2];
    bit         m_co  [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic longint sel_x(input logic [1:0] s, input longint p);
        case (s)
            2'd0: return 0;
            2'd1: return longint'(m);
            2'd2: return p;
            default: return longint'(dab);
        endcase
    endfunction

    function automatic longint sel_z(input logic [1:0] s, input longint p);
        case (s)
            2'd0: return 0;
            2'd1: return longint'(pcin);
            2'd2: return p;
            default: return longint'(c);
        endcase
    endfunction

    task automatic step();
        logic [7:0] n_opm;
        bit         n_cin [2];
        longint     n_p   [2];
        bit         n_co  [2];
        longint     x, z, r;
        n_opm = m_opm;
        for (int k = 0; k < 2; k++) begin
            n_cin[k] = m_cin[k]; n_p[k] = m_p[k]; n_co[k] = m_co[k];
        end
        if (reset) begin
            n_opm = '0;
            for (int k = 0; k < 2; k++) begin
                n_cin[k] = 0; n_p[k] = 0; n_co[k] = 0;
            end
        end else begin
            if (ce_opm) n_opm = opmode;
            for (int k = 0; k < 2; k++) begin
                if (ce_cin) n_cin[k] = (k == 0) ? opmode[5] : carryin;
                if (ce_p) begin
                    x = sel_x(m_opm[1:0], m_p[k]);
                    z = sel_z(m_opm[3:2], m_p[k]);
                    if (m_opm[7]) r = (z - (x + longint'(m_cin[k]))) & MASK49;
                    else          r = (z + x + longint'(m_cin[k])) & MASK49;
                    n_p[k]  = r & MASK48;
                    n_co[k] = ((r >> 48) & 1) != 0;
                end
            end
        end
        @(posedge CLK);
        #1;
        m_opm = n_opm;
        for (int k = 0; k < 2; k++) begin
            m_cin[k] = n_cin[k]; m_p[k] = n_p[k]; m_co[k] = n_co[k];
        end
        check("P0",         64'(bus0.P),         m_p[0]);
        check("PCOUT0",     64'(bus0.PCOUT),     m_p[0]);
        check("CARRYOUT0",  64'(bus0.CARRYOUT),  64'(m_co[0]));
        check("CARRYOUTF0", 64'(bus0.CARRYOUTF), 64'(m_co[0]));
        check("P1",         64'(bus1.P),         m_p[1]);
        check("PCOUT1",     64'(bus1.PCOUT),     m_p[1]);
        check("CARRYOUT1",  64'(bus1.CARRYOUT),  64'(m_co[1]));
        check("CARRYOUTF1", 64'(bus1.CARRYOUTF), 64'(m_co[1]));
    endtask

    initial begin
        logic [63:0] t;
        m_opm = '0;
        for (int k = 0; k < 2; k++) begin
            m_cin[k] = 0; m_p[k] = 0; m_co[k] = 0;
        end
        reset = 1'b1; ce_opm = 1'b1; ce_cin = 1'b1; ce_p = 1'b1;
        opmode = '0; carryin = 1'b0; m = '0; c = '0; dab = '0; pcin = '0;

        step();
        check("rst_P", 64'(bus0.P), 64'd0);
        check("rst_CO", 64'(bus0.CARRYOUT), 64'd0);

        // Reset: load P=0x123, then freeze and hit it with reset
        reset = 1'b0; opmode = 8'b0000_1100; c = 48'h123;
        step(); step();
        check("t1_load", 64'(bus0.P), 64'h123);
        ce_p = 1'b0;
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        step();
        check("t1_async", 64'(bus0.P), 64'h123);
        reset = 1'b1;
        step();
        check("t1_sync_P", 64'(bus0.P), 64'd0);
        check("t1_sync_CO", 64'(bus0.CARRYOUT), 64'd0);
        reset = 1'b0; ce_p = 1'b1;

        // Multiply-add
        opmode = 8'b0000_1101; m = 36'd1000; c = 48'd24;
        step(); step();
        check("t2_P", 64'(bus0.P), 64'd1024);
        check("t2_CO", 64'(bus0.CARRYOUT), 64'd0);

        // Accumulate with a CEP pause
        reset = 1'b1; step(); reset = 1'b0;
        opmode = 8'b0000_1001; m = 36'd5;
        step();
        step(); check("t3_acc5", 64'(bus0.P), 64'd5);
        step(); check("t3_acc10", 64'(bus0.P), 64'd10);
        step(); check("t3_acc15", 64'(bus0.P), 64'd15);
        ce_p = 1'b0;
        step(); step(); step();
        check("t3_hold", 64'(bus0.P), 64'd15);
        ce_p = 1'b1;
        step(); check("t3_resume", 64'(bus0.P), 64'd20);

        // Subtract and borrow
        opmode = 8'b1000_1101; c = 48'd100; m = 36'd30;
        step(); step();
        check("t4_sub", 64'(bus0.P), 64'd70);
        check("t4_sub_CO", 64'(bus0.CARRYOUT), 64'd0);
        c = 48'd0; m = 36'd1;
        step();
        check("t4_borrow", 64'(bus0.P), 64'hFFFF_FFFF_FFFF);
        check("t4_borrow_CO", 64'(bus0.CARRYOUT), 64'd1);

        // Wrap with carry-in from OPMODE[5]
        opmode = 8'b0010_0011; dab = '1;
        step(); step();
        check("t5_P", 64'(bus0.P), 64'd0);
        check("t5_PCOUT", 64'(bus0.PCOUT), 64'd0);
        check("t5_CO", 64'(bus0.CARRYOUT), 64'd1);
        check("t5_COF", 64'(bus0.CARRYOUTF), 64'd1);

        // External carry-in, then frozen carry-in register
        opmode = 8'b0000_1100; c = 48'd7; carryin = 1'b1;
        step(); step();
        check("t6_cin", 64'(bus1.P), 64'd8);
        ce_cin = 1'b0; carryin = 1'b0;
        step(); step();
        check("t6_cin_hold", 64'(bus1.P), 64'd8);
        ce_cin = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            opmode  = 8'($urandom());
            carryin = 1'($urandom());
            t = {$urandom(), $urandom()}; m = t[35:0];
            t = {$urandom(), $urandom()}; c = t[47:0];
            t = {$urandom(), $urandom()}; dab = t[47:0];
            t = {$urandom(), $urandom()}; pcin = t[47:0];
            if ($urandom_range(0, 7) == 0) dab = '1;
            if ($urandom_range(0, 7) == 0) c = '0;
            ce_opm = ($urandom_range(0, 7) != 0);
            ce_cin = ($urandom_range(0, 7) != 0);
            ce_p   = ($urandom_range(0, 7) != 0);
            reset  = ($urandom_range(0, 31) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
